// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-first bypass read ports and a
// busy-bit scoreboard. After reset a sequencer zeroes the array one entry per
// cycle before the file reports ready.
//
// state | meaning
// INIT  | clearing regs[cnt], ports forced to zero, control inputs ignored
// RUN   | normal read/write/scoreboard operation, ready_o high
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic                ready_o
);

  typedef enum logic {INIT, RUN} state_e;

  // Widened so that NREG == 2**AW still compares correctly.
  localparam logic [AW:0] NREG_W  = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST  = AW'(NREG - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [NREG-1:0]      busy_q, busy_d;
  logic                 ready_q;
  logic [XLEN-1:0]      regs [NREG];

  logic                 mem_we;
  logic [AW-1:0]        mem_wa;
  logic [XLEN-1:0]      mem_wd;

  // Address names a writable architectural register (not x0, not past NREG).
  function automatic logic in_rng(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_W);
  endfunction

  // Next-state, init sequencing, write-port select and scoreboard update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    mem_wa  = wb_addr_i;
    mem_wd  = wb_data_i;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        if (cnt_q == LAST) state_d = RUN;
        else               cnt_d   = cnt_q + AW'(1);
      end
      RUN: begin
        mem_we = wb_en_i && in_rng(wb_addr_i);
        for (int i = 1; i < NREG; i++) begin
          if (flush_i)                                busy_d[i] = 1'b0;
          else if (iss_en_i && iss_addr_i == AW'(i))  busy_d[i] = 1'b1;
          else if (wb_en_i && wb_addr_i == AW'(i))    busy_d[i] = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
    busy_d[0] = 1'b0;
  end

  // Control state; synchronous active-low reset restarts initialisation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= (state_d == RUN);
    end
  end

  // Register array; contents are left alone while reset is held.
  always_ff @(posedge clk) begin
    if (rst && mem_we) regs[mem_wa] <= mem_wd;
  end

  // Combinational read ports with write-first bypass and busy masking.
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    hit       = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra  = rd_addr_i[k*AW +: AW];
      hit = wb_en_i && (wb_addr_i == ra);
      if (state_q == RUN && in_rng(ra)) begin
        rd_data_o[k*XLEN +: XLEN] = hit ? wb_data_i : regs[ra];
        rd_busy_o[k]              = busy_q[ra] && !hit;
      end
    end
  end

  assign ready_o = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: init timing, bypass, x0, scoreboard
// collisions, flush and mid-run reset.
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                wb_en_i;
  logic [AW-1:0]       wb_addr_i;
  logic [XLEN-1:0]     wb_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_addr_i;
  logic                flush_i;
  logic                ready_o;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i), .flush_i(flush_i),
    .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   rd0;
    logic [AW-1:0]   rd1;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            flush;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic            eb0;
    logic            eb1;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_addr_i  = '0;
    wb_en_i    = 1'b0;
    wb_addr_i  = '0;
    wb_data_i  = '0;
    iss_en_i   = 1'b0;
    iss_addr_i = '0;
    flush_i    = 1'b0;
  endtask

  // Drive, check combinational outputs mid-cycle, then take the clock edge.
  task automatic apply(input vec_t v, input int idx);
    rd_addr_i  = {v.rd1, v.rd0};
    wb_en_i    = v.wb_en;
    wb_addr_i  = v.wb_addr;
    wb_data_i  = v.wb_data;
    iss_en_i   = v.iss_en;
    iss_addr_i = v.iss_addr;
    flush_i    = v.flush;
    #2;
    chk($sformatf("vec%0d data0", idx), rd_data_o[XLEN-1:0], v.e0);
    chk($sformatf("vec%0d data1", idx), rd_data_o[2*XLEN-1:XLEN], v.e1);
    chk($sformatf("vec%0d busy0", idx), XLEN'(rd_busy_o[0]), XLEN'(v.eb0));
    chk($sformatf("vec%0d busy1", idx), XLEN'(rd_busy_o[1]), XLEN'(v.eb1));
    @(posedge clk); #1;
  endtask

  // Count edges after reset release; ready must rise exactly on edge NREG.
  // Inputs are kept active during INIT to show they are ignored.
  task automatic init_seq(input string tag);
    for (int e = 1; e <= NREG; e++) begin
      rd_addr_i  = {AW'(7), AW'(5)};
      wb_en_i    = 1'b1;
      wb_addr_i  = AW'(5);
      wb_data_i  = 64'hAAAA_5555_AAAA_5555;
      iss_en_i   = 1'b1;
      iss_addr_i = AW'(25);
      @(posedge clk); #1;
      chk($sformatf("%s ready edge%0d", tag, e), XLEN'(ready_o), XLEN'(e == NREG));
      if (e < NREG) begin
        #1;
        chk($sformatf("%s init rd edge%0d", tag, e), rd_data_o[XLEN-1:0] | rd_data_o[2*XLEN-1:XLEN], '0);
        chk($sformatf("%s init busy edge%0d", tag, e), XLEN'(rd_busy_o), '0);
      end
    end
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREG; a++) begin
      rd_addr_i = {AW'(a), AW'(a)};
      #1;
      chk($sformatf("%s zero x%0d p0", tag, a), rd_data_o[XLEN-1:0], '0);
      chk($sformatf("%s zero x%0d p1", tag, a), rd_data_o[2*XLEN-1:XLEN], '0);
      chk($sformatf("%s busy x%0d", tag, a), XLEN'(rd_busy_o), '0);
    end
  endtask

  initial begin
    //        rd0 rd1 wben wba wbdata                  iss isa fl  e0                      e1                      eb0 eb1
    vecs[0]  = '{5,  0,  1,  5, 64'hDEADBEEF_00000001, 0,  0, 0, 64'hDEADBEEF_00000001, 0,                      0, 0};
    vecs[1]  = '{5,  5,  0,  0, 0,                     0,  0, 0, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001, 0, 0};
    vecs[2]  = '{0,  0,  1,  0, 64'hFFFFFFFF_FFFFFFFF, 1,  0, 0, 0,                      0,                      0, 0};
    vecs[3]  = '{0,  0,  0,  0, 0,                     0,  0, 0, 0,                      0,                      0, 0};
    vecs[4]  = '{7,  5,  0,  0, 0,                     1,  7, 0, 0,                      64'hDEADBEEF_00000001, 0, 0};
    vecs[5]  = '{7,  7,  0,  0, 0,                     0,  0, 0, 0,                      0,                      1, 1};
    vecs[6]  = '{7,  3,  1,  7, 64'h42,                0,  0, 0, 64'h42,                 0,                      0, 0};
    vecs[7]  = '{7,  7,  0,  0, 0,                     0,  0, 0, 64'h42,                 64'h42,                 0, 0};
    vecs[8]  = '{9,  9,  1,  9, 64'h11,                1,  9, 0, 64'h11,                 64'h11,                 0, 0};
    vecs[9]  = '{9,  9,  0,  0, 0,                     0,  0, 0, 64'h11,                 64'h11,                 1, 1};
    vecs[10] = '{10, 9,  0,  0, 0,                     1, 10, 0, 0,                      64'h11,                 0, 1};
    vecs[11] = '{10, 9,  1, 12, 64'h77,                1, 10, 1, 0,                      64'h11,                 1, 1};
    vecs[12] = '{10, 12, 0,  0, 0,                     0,  0, 0, 0,                      64'h77,                 0, 0};
    vecs[13] = '{9,  10, 0,  0, 0,                     0,  0, 0, 64'h11,                 0,                      0, 0};
    vecs[14] = '{20, 20, 0,  0, 0,                     1, 20, 0, 0,                      0,                      0, 0};
    vecs[15] = '{20, 20, 0,  0, 0,                     1, 20, 0, 0,                      0,                      1, 1};
    vecs[16] = '{20, 7,  1, 20, 64'h5,                 0,  0, 0, 64'h5,                  64'h42,                 0, 0};
    vecs[17] = '{20, 7,  0,  0, 0,                     0,  0, 0, 64'h5,                  64'h42,                 0, 0};

    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", XLEN'(ready_o), '0);
    rst = 1'b1;
    init_seq("init");
    check_all_zero("post-init");

    for (int i = 0; i < 18; i++) apply(vecs[i], i);

    // Mid-run reset: x3 and a busy x25 must both come back cleared.
    apply('{3, 0, 1, 3, 64'h55, 1, 25, 0, 64'h55, 0, 0, 0}, 100);
    apply('{3, 25, 0, 0, 0, 0, 0, 0, 64'h55, 0, 0, 1}, 101);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrun reset ready", XLEN'(ready_o), '0);
    rst = 1'b1;
    init_seq("reinit");
    rd_addr_i = {AW'(25), AW'(3)};
    #1;
    chk("reinit x3", rd_data_o[XLEN-1:0], '0);
    chk("reinit busy", XLEN'(rd_busy_o), '0);
    check_all_zero("post-reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
